// File: rtl/mem_access_unit.sv
// Memory-stage controller: drives the data-memory req/ack bus for loads and
// stores, stalls upstream while an access is outstanding, resolves branch/jump
// redirection and registers the write-back fields.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        branch_in,
  input  logic        jump_in,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_write,
  input  logic        mem_to_reg,
  input  logic [31:0] branch_target,
  input  logic [1:0]  alu_zero,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  dest_reg,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        pc_src,
  output logic [31:0] pc_target,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic        wb_mem_to_reg,
  output logic [31:0] wb_read_data,
  output logic [31:0] wb_alu_result,
  output logic [4:0]  wb_dest_reg,
  output logic        mem_err
);

  // Counter only needs to reach TIMEOUT-1.
  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          cap_reg_write;
  logic          cap_mem_to_reg;
  logic [4:0]    cap_dest_reg;

  logic is_idle, is_busy;
  logic mem_op, accept, illegal, alu_op;
  logic ack_hit, timeout_hit;
  logic unused_alu_zero;

  assign is_idle     = (state == IDLE);
  assign is_busy     = (state == BUSY);
  assign mem_op      = mem_read | mem_write;
  assign alu_op      = is_idle & in_valid & ~mem_op;
  assign accept      = is_idle & in_valid & (mem_read ^ mem_write) & (alu_result[1:0] == 2'b00);
  assign illegal     = is_idle & in_valid & mem_op &
                       ((mem_read & mem_write) | (alu_result[1:0] != 2'b00));
  assign ack_hit     = is_busy & mem_ack;
  assign timeout_hit = is_busy & (cnt == CW'(TIMEOUT - 1)) & ~mem_ack;

  // Request is exactly the BUSY state, so reset drops it asynchronously.
  assign mem_req = is_busy;

  // Redirect resolves combinationally; only bit 0 of the ALU flags is the zero flag.
  assign pc_src          = in_valid & is_idle & (jump_in | (branch_in & alu_zero[0]));
  assign pc_target       = branch_target;
  assign unused_alu_zero = alu_zero[1];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and stall decode.
  always_comb begin
    state_nx = state;
    stall    = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = BUSY;
          stall    = 1'b1;
        end
      end
      BUSY: begin
        stall = ~mem_ack & ~timeout_hit;
        if (ack_hit || timeout_hit) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Bus fields and pending write-back controls captured on accept; held through BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      cap_reg_write  <= 1'b0;
      cap_mem_to_reg <= 1'b0;
      cap_dest_reg   <= '0;
      cnt            <= '0;
    end else if (accept) begin
      mem_we         <= mem_write;
      mem_addr       <= alu_result;
      mem_wdata      <= store_data;
      cap_reg_write  <= reg_write;
      cap_mem_to_reg <= mem_to_reg;
      cap_dest_reg   <= dest_reg;
      cnt            <= '0;
    end else if (is_busy) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Write-back register and error pulse; ack in the final cycle beats timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_read_data  <= '0;
      wb_alu_result <= '0;
      wb_dest_reg   <= '0;
      mem_err       <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      mem_err  <= 1'b0;
      if (alu_op) begin
        wb_valid      <= 1'b1;
        wb_reg_write  <= reg_write;
        wb_mem_to_reg <= mem_to_reg;
        wb_alu_result <= alu_result;
        wb_dest_reg   <= dest_reg;
        wb_read_data  <= '0;
      end else if (ack_hit) begin
        wb_valid      <= 1'b1;
        wb_reg_write  <= cap_reg_write & ~mem_we;
        wb_mem_to_reg <= cap_mem_to_reg;
        wb_alu_result <= mem_addr;
        wb_dest_reg   <= cap_dest_reg;
        if (!mem_we) wb_read_data <= mem_rdata;
      end else if (illegal || timeout_hit) begin
        mem_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a write-back scoreboard.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, branch_in, jump_in, mem_read, mem_write, reg_write, mem_to_reg;
  logic [31:0] branch_target, alu_result, store_data, mem_rdata;
  logic [1:0]  alu_zero;
  logic [4:0]  dest_reg;
  logic        mem_ack;
  logic        mem_req, mem_we, stall, pc_src, wb_valid, wb_reg_write, wb_mem_to_reg, mem_err;
  logic [31:0] mem_addr, mem_wdata, pc_target, wb_read_data, wb_alu_result;
  logic [4:0]  wb_dest_reg;

  mem_access_unit #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .branch_in(branch_in), .jump_in(jump_in),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .branch_target(branch_target), .alu_zero(alu_zero), .alu_result(alu_result),
    .store_data(store_data), .dest_reg(dest_reg), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .pc_src(pc_src), .pc_target(pc_target), .wb_valid(wb_valid),
    .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg), .wb_read_data(wb_read_data),
    .wb_alu_result(wb_alu_result), .wb_dest_reg(wb_dest_reg), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    bit          rw;
    bit          m2r;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  dst;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_rd = '0;
  int          n_total = 0;
  int          n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic idle();
    in_valid = 0; branch_in = 0; jump_in = 0; mem_read = 0; mem_write = 0;
    reg_write = 0; mem_to_reg = 0; branch_target = '0; alu_zero = '0;
    alu_result = '0; store_data = '0; dest_reg = '0; mem_ack = 0; mem_rdata = 32'h5555_5555;
  endtask

  task automatic drive(input bit rd, input bit wr, input bit rw, input bit m2r,
                       input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] dst);
    idle();
    in_valid = 1; mem_read = rd; mem_write = wr; reg_write = rw; mem_to_reg = m2r;
    alu_result = addr; store_data = sd; dest_reg = dst;
  endtask

  task automatic push_ok(input bit rw, input bit m2r, input logic [31:0] rd,
                         input logic [31:0] alu, input logic [4:0] dst);
    exp_t e;
    e.err = 0; e.rw = rw; e.m2r = m2r; e.rd = rd; e.alu = alu; e.dst = dst;
    sb.push_back(e);
    last_rd = rd;
  endtask

  task automatic push_err();
    exp_t e;
    e.err = 1; e.rw = 0; e.m2r = 0; e.rd = '0; e.alu = '0; e.dst = '0;
    sb.push_back(e);
  endtask

  // Scoreboard: every write-back or error event must match the next expected entry.
  always @(posedge clk) begin
    #3;
    if (rst_n && (wb_valid || mem_err)) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_mem_err", mem_err, e.err);
        chk("sb_wb_valid", wb_valid, !e.err);
        if (!e.err) begin
          chk("sb_wb_reg_write", wb_reg_write, e.rw);
          chk("sb_wb_mem_to_reg", wb_mem_to_reg, e.m2r);
          chk("sb_wb_read_data", wb_read_data, e.rd);
          chk("sb_wb_alu_result", wb_alu_result, e.alu);
          chk("sb_wb_dest_reg", wb_dest_reg, e.dst);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    idle();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_stall", stall, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wb_alu_result", wb_alu_result, 0);
    rst_n = 1;

    // ALU op: write-back one cycle later, no stall.
    @(negedge clk); drive(0, 0, 1, 0, 32'h1234, '0, 5'd5); push_ok(1, 0, '0, 32'h1234, 5'd5);
    #1 chk("alu_stall", stall, 0);
    @(negedge clk); idle();
    #1 chk("alu_wb_valid", wb_valid, 1);
    chk("alu_stall_after", stall, 0);

    // Load at 0x100, ack on third request cycle; inputs during BUSY ignored.
    @(negedge clk); drive(1, 0, 1, 1, 32'h100, '0, 5'd7); push_ok(1, 1, 32'hDEAD_BEEF, 32'h100, 5'd7);
    #1 chk("ld_stall_accept", stall, 1);
    chk("ld_req_accept", mem_req, 0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk); idle();
      if (i < 3) begin in_valid = 1; jump_in = 1; end
      else begin mem_ack = 1; mem_rdata = 32'hDEAD_BEEF; end
      #1;
      chk("ld_req", mem_req, 1);
      chk("ld_addr", mem_addr, 32'h100);
      chk("ld_we", mem_we, 0);
      chk("ld_stall", stall, 32'(i < 3));
      chk("ld_pc_src_busy", pc_src, 0);
    end
    @(negedge clk); idle();
    #1 chk("ld_wb_valid", wb_valid, 1);
    chk("ld_req_done", mem_req, 0);

    // Misaligned store and read+write: error pulse, no bus access.
    @(negedge clk); drive(0, 1, 0, 0, 32'h102, 32'h1234_5678, 5'd0); push_err();
    #1 chk("mis_stall", stall, 0);
    @(negedge clk); drive(1, 1, 1, 0, 32'h108, '0, 5'd4); push_err();
    #1 chk("mis_req", mem_req, 0);
    chk("mis_err", mem_err, 1);
    chk("mis_wb_valid", wb_valid, 0);
    @(negedge clk); idle();
    #1 chk("rw_req", mem_req, 0);
    chk("rw_err", mem_err, 1);

    // Store at 0x104, immediate ack; reg_write forced low, read data held.
    @(negedge clk); drive(0, 1, 1, 0, 32'h104, 32'hA5A5_A5A5, 5'd3); push_ok(0, 0, last_rd, 32'h104, 5'd3);
    #1 chk("st_stall_accept", stall, 1);
    @(negedge clk); idle(); mem_ack = 1;
    #1 chk("st_req", mem_req, 1);
    chk("st_we", mem_we, 1);
    chk("st_wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("st_addr", mem_addr, 32'h104);
    chk("st_stall", stall, 0);
    @(negedge clk); idle();
    #1 chk("st_wb_valid", wb_valid, 1);
    chk("st_wb_reg_write", wb_reg_write, 0);

    // No ack: request for exactly TIMEOUT cycles, then error.
    @(negedge clk); drive(1, 0, 1, 1, 32'h200, '0, 5'd9); push_err();
    #1 chk("to_stall_accept", stall, 1);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); idle();
      #1 chk("to_req", mem_req, 1);
      chk("to_stall", stall, 32'(i < 4));
      chk("to_err_early", mem_err, 0);
    end
    @(negedge clk); idle();
    #1 chk("to_req_drop", mem_req, 0);
    chk("to_err", mem_err, 1);
    chk("to_wb_valid", wb_valid, 0);

    // Ack on the last allowed cycle wins over timeout.
    @(negedge clk); drive(1, 0, 1, 1, 32'h204, '0, 5'd10); push_ok(1, 1, 32'h0BAD_F00D, 32'h204, 5'd10);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); idle();
      if (i == 4) begin mem_ack = 1; mem_rdata = 32'h0BAD_F00D; end
      #1 chk("ack4_req", mem_req, 1);
      chk("ack4_stall", stall, 32'(i < 4));
    end
    @(negedge clk); idle();
    #1 chk("ack4_wb_valid", wb_valid, 1);
    chk("ack4_err", mem_err, 0);
    chk("ack4_req_drop", mem_req, 0);

    // Redirect: taken branch, not-taken (zero clear, then only bit 1 set), jump.
    @(negedge clk); drive(0, 0, 0, 0, 32'h44, '0, 5'd0); branch_in = 1; alu_zero = 2'b01;
    branch_target = 32'h40; push_ok(0, 0, '0, 32'h44, 5'd0);
    #1 chk("br_pc_src", pc_src, 1);
    chk("br_pc_target", pc_target, 32'h40);
    chk("br_stall", stall, 0);
    @(negedge clk); drive(0, 0, 0, 0, 32'h48, '0, 5'd0); branch_in = 1; alu_zero = 2'b00;
    branch_target = 32'h40; push_ok(0, 0, '0, 32'h48, 5'd0);
    #1 chk("brnt_pc_src", pc_src, 0);
    @(negedge clk); drive(0, 0, 0, 0, 32'h4C, '0, 5'd0); branch_in = 1; alu_zero = 2'b10;
    push_ok(0, 0, '0, 32'h4C, 5'd0);
    #1 chk("brz1_pc_src", pc_src, 0);
    @(negedge clk); drive(0, 0, 0, 0, 32'h50, '0, 5'd0); jump_in = 1; branch_target = 32'h80;
    push_ok(0, 0, '0, 32'h50, 5'd0);
    #1 chk("jmp_pc_src", pc_src, 1);
    chk("jmp_pc_target", pc_target, 32'h80);
    @(negedge clk); idle(); jump_in = 1;
    #1 chk("jmp_invalid_pc_src", pc_src, 0);

    // Reset during an outstanding load, then a stray ack.
    @(negedge clk); drive(1, 0, 1, 1, 32'h300, '0, 5'd2); push_ok(1, 1, 32'h7777_7777, 32'h300, 5'd2);
    @(negedge clk); idle();
    #1 chk("mid_req_before", mem_req, 1);
    rst_n = 0;
    #1 chk("mid_req", mem_req, 0);
    chk("mid_stall", stall, 0);
    chk("mid_wb_valid", wb_valid, 0);
    chk("mid_wb_alu_result", wb_alu_result, 0);
    chk("mid_mem_addr", mem_addr, 0);
    sb.delete();
    last_rd = '0;
    @(negedge clk); rst_n = 1; mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    #1 chk("stray_stall", stall, 0);
    @(negedge clk); idle();
    #1 chk("stray_wb_valid", wb_valid, 0);
    chk("stray_req", mem_req, 0);
    chk("stray_rd", wb_read_data, 0);

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
